// File: rtl/serial_paralelo_sync.sv
// serial_paralelo_sync -- serial-to-parallel converter with comma alignment.
//
// Shifts a serial bit stream (MSB of each word first) into a WIDTH-bit
// register, hunts for the COMMA symbol, confirms word alignment with
// LOCK_COUNT consecutive commas, then emits every non-comma word on
// data_out with a one-cycle valid_out pulse.
//
// Optional feature macro: SP_LOSS_DET_EN
//   defined   : while locked, more than LOSS_WORDS consecutive non-comma
//               words drop the link back to SEARCH.
//   undefined : lock is sticky until reset; no gap counter exists.
//
// Ports:
//   clk_32f    in   bit clock, all logic on rising edge
//   reset_L    in   synchronous active-low reset
//   data_in    in   serial data
//   data_out   out  [WIDTH-1:0] last received data word (registered)
//   valid_out  out  one-cycle pulse when data_out takes a new word
//   active     out  high while LOCKED
//   sync_state out  [1:0] 0 SEARCH, 1 ALIGN, 2 LOCKED
module serial_paralelo_sync #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'('hBC),
  parameter int               LOCK_COUNT = 4,
  parameter int               LOSS_WORDS = 4
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active,
  output logic [1:0]       sync_state
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = $clog2(LOCK_COUNT + 1);

  localparam bit PARAMS_OK = (WIDTH >= 4) && (WIDTH <= 32) &&
                             (LOCK_COUNT >= 1) && (LOCK_COUNT <= 15) &&
                             (LOSS_WORDS >= 1) && (LOSS_WORDS <= 255);

  if (!PARAMS_OK) begin : g_param_check
    $error("serial_paralelo_sync: parameter out of legal range");
  end

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [BW-1:0]    bcnt;
  logic [BW-1:0]    bcnt_inc;
  logic [CW-1:0]    comma_cnt;
  logic             boundary;
  logic             is_comma;

`ifdef SP_LOSS_DET_EN
  localparam int GW = $clog2(LOSS_WORDS + 1);
  logic [GW-1:0]    gap;
`endif

  assign sr_next    = {sr[WIDTH-2:0], data_in};
  assign is_comma   = (sr_next == COMMA);
  // The word's last bit is being sampled on this edge.
  assign boundary   = (bcnt == BW'(WIDTH - 1));
  assign bcnt_inc   = boundary ? '0 : bcnt + BW'(1);
  assign sync_state = state;

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state     <= SEARCH;
      sr        <= '0;
      bcnt      <= '0;
      comma_cnt <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
`ifdef SP_LOSS_DET_EN
      gap       <= '0;
`endif
    end else begin
      sr        <= sr_next;
      valid_out <= 1'b0;
      case (state)
        SEARCH: begin
          // sr_next slides one bit per cycle, so testing it every cycle
          // covers every bit offset of the incoming stream.
          if (is_comma) begin
            bcnt <= '0;  // comma ends here; next word ends WIDTH cycles on
            if (LOCK_COUNT == 1) begin
              state     <= LOCKED;
              active    <= 1'b1;
              comma_cnt <= CW'(1);
            end else begin
              state     <= ALIGN;
              comma_cnt <= CW'(1);
            end
          end
        end

        ALIGN: begin
          bcnt <= bcnt_inc;
          if (boundary) begin
            if (is_comma) begin
              comma_cnt <= comma_cnt + CW'(1);
              if (comma_cnt == CW'(LOCK_COUNT - 1)) begin
                state  <= LOCKED;
                active <= 1'b1;
              end
            end else begin
              state     <= SEARCH;
              comma_cnt <= '0;
            end
          end
        end

        LOCKED: begin
          bcnt <= bcnt_inc;
          if (boundary) begin
            if (is_comma) begin
`ifdef SP_LOSS_DET_EN
              gap <= '0;
`endif
            end else begin
`ifdef SP_LOSS_DET_EN
              // One non-comma word too many: drop it and re-hunt.
              if (gap == GW'(LOSS_WORDS)) begin
                state     <= SEARCH;
                active    <= 1'b0;
                gap       <= '0;
                comma_cnt <= '0;
                bcnt      <= '0;
              end else begin
                gap       <= gap + GW'(1);
                data_out  <= sr_next;
                valid_out <= 1'b1;
              end
`else
              data_out  <= sr_next;
              valid_out <= 1'b1;
`endif
            end
          end
        end

        default: begin
          state     <= SEARCH;
          active    <= 1'b0;
          comma_cnt <= '0;
          bcnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Directed bench for serial_paralelo_sync (WIDTH=8, COMMA=BC,
// LOCK_COUNT=4, LOSS_WORDS=4). Bits are driven on the falling edge and
// outputs are sampled 1ns after the rising edge that consumed the bit.
module tb_serial_paralelo_sync;

  localparam int W = 8;

  logic         clk_32f = 1'b0;
  logic         reset_L = 1'b0;
  logic         data_in = 1'b0;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         active;
  logic [1:0]   sync_state;

  int checks = 0;
  int errors = 0;
  int nv;

  serial_paralelo_sync #(
    .WIDTH(W), .COMMA(8'hBC), .LOCK_COUNT(4), .LOSS_WORDS(4)
  ) dut (
    .clk_32f(clk_32f), .reset_L(reset_L), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .active(active),
    .sync_state(sync_state)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // Shift one word MSB first; n counts valid pulses seen over its bits.
  task automatic send_word(input logic [W-1:0] w, output int n);
    n = 0;
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(w[i]);
      if (valid_out) n++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".data"},   32'(data_out),   32'h0);
    chk({tag, ".valid"},  32'(valid_out),  32'h0);
    chk({tag, ".active"}, 32'(active),     32'h0);
    chk({tag, ".state"},  32'(sync_state), 32'h0);
  endtask

  task automatic lock4(input string tag);
    for (int k = 1; k <= 3; k++) begin
      send_word(8'hBC, nv);
      chk({tag, ".align_state"}, 32'(sync_state), 32'd1);
      chk({tag, ".align_active"}, 32'(active), 32'd0);
    end
    send_word(8'hBC, nv);
    chk({tag, ".lock_active"}, 32'(active), 32'd1);
    chk({tag, ".lock_state"},  32'(sync_state), 32'd2);
    chk({tag, ".lock_novalid"}, 32'(nv), 32'd0);
  endtask

  initial begin
    // Reset with random serial data.
    reset_L = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_32f);
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk_32f);
      #1;
    end
    chk_all_zero("reset");
    @(negedge clk_32f);
    reset_L = 1'b1;

    // Three garbage bits, then lock on four commas, then two data words.
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    chk("garbage.state", 32'(sync_state), 32'd0);
    lock4("lock");
    send_word(8'h5A, nv);
    chk("w5A.valid", 32'(valid_out), 32'd1);
    chk("w5A.data",  32'(data_out),  32'h5A);
    chk("w5A.npulse", 32'(nv), 32'd1);
    send_word(8'hC3, nv);
    chk("wC3.valid", 32'(valid_out), 32'd1);
    chk("wC3.data",  32'(data_out),  32'hC3);
    chk("wC3.npulse", 32'(nv), 32'd1);

    // Comma while locked holds data_out without a pulse.
    send_word(8'h11, nv);
    chk("w11.data", 32'(data_out), 32'h11);
    chk("w11.npulse", 32'(nv), 32'd1);
    send_word(8'hBC, nv);
    chk("idleBC.npulse", 32'(nv), 32'd0);
    chk("idleBC.data", 32'(data_out), 32'h11);
    chk("idleBC.active", 32'(active), 32'd1);
    send_word(8'h22, nv);
    chk("w22.valid", 32'(valid_out), 32'd1);
    chk("w22.data", 32'(data_out), 32'h22);

    // Five consecutive data words after a comma.
    send_word(8'hBC, nv);
    for (int k = 1; k <= 4; k++) begin
      send_word(W'(k), nv);
      chk("gap.valid", 32'(valid_out), 32'd1);
      chk("gap.data",  32'(data_out),  32'(k));
    end
    send_word(8'h05, nv);
`ifdef SP_LOSS_DET_EN
    chk("loss.npulse", 32'(nv), 32'd0);
    chk("loss.data",   32'(data_out), 32'h04);
    chk("loss.active", 32'(active), 32'd0);
    chk("loss.state",  32'(sync_state), 32'd0);
`else
    chk("noloss.npulse", 32'(nv), 32'd1);
    chk("noloss.data",   32'(data_out), 32'h05);
    chk("noloss.active", 32'(active), 32'd1);
    chk("noloss.state",  32'(sync_state), 32'd2);
`endif

    // Reset pulse while locked, at bit 3 of a word.
    @(negedge clk_32f);
    reset_L = 1'b0;
    @(posedge clk_32f);
    @(negedge clk_32f);
    reset_L = 1'b1;
    lock4("relock1");
    send_word(8'h77, nv);
    chk("w77.data", 32'(data_out), 32'h77);
    chk("w77.npulse", 32'(nv), 32'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    @(negedge clk_32f);
    reset_L = 1'b0;
    data_in = 1'b1;
    @(posedge clk_32f);
    #1;
    chk_all_zero("midrst");
    @(negedge clk_32f);
    reset_L = 1'b1;
    lock4("relock2");

    // Aborted alignment: BC, BC, 12, then idle zeros.
    @(negedge clk_32f);
    reset_L = 1'b0;
    @(posedge clk_32f);
    @(negedge clk_32f);
    reset_L = 1'b1;
    send_word(8'hBC, nv);
    send_word(8'hBC, nv);
    chk("abort.align", 32'(sync_state), 32'd1);
    send_word(8'h12, nv);
    chk("abort.state",  32'(sync_state), 32'd0);
    chk("abort.active", 32'(active), 32'd0);
    chk("abort.npulse", 32'(nv), 32'd0);
    send_word(8'h00, nv);
    send_word(8'h00, nv);
    chk("idle.state",  32'(sync_state), 32'd0);
    chk("idle.npulse", 32'(nv), 32'd0);
    chk("idle.data",   32'(data_out), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
